// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared definitions for the SPI receive path.
//   spi_state_e          receiver FSM state encodings
//   SPI_MIN_PHASE_CYCLES fewest spi_clk cycles the transmitter holds each
//                        serial-clock phase (also used by the transmitter's
//                        CLOCK_DELAY_TIME check)
//   SPI_BYTE_W           width of one reassembled byte
package spi_rx_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE     = 2'd0,
    STATE_RECEIVE  = 2'd1,
    STATE_COMPLETE = 2'd2
  } spi_state_e;

  localparam int SPI_MIN_PHASE_CYCLES = 3;
  localparam int SPI_BYTE_W           = 8;

endpackage

// File: rtl/spi_rx_if.sv
// spi_rx_if: serial input pair plus byte handshake of the SPI receiver.
//   spi_input_clock / spi_input_data : asynchronous serial clock and data
//   spi_data_out / spi_data_valid    : delivered byte and its valid flag
//   spi_data_ack                     : consumer takes the byte
//   spi_busy / spi_overrun / spi_frame_error : status
// Modports: slave = receiver, master = transmitter/consumer side.
interface spi_rx_if;
  import spi_rx_pkg::*;

  logic                  spi_input_clock;
  logic                  spi_input_data;
  logic [SPI_BYTE_W-1:0] spi_data_out;
  logic                  spi_data_valid;
  logic                  spi_data_ack;
  logic                  spi_busy;
  logic                  spi_overrun;
  logic                  spi_frame_error;

  modport slave (
    input  spi_input_clock, spi_input_data, spi_data_ack,
    output spi_data_out, spi_data_valid, spi_busy, spi_overrun, spi_frame_error
  );

  modport master (
    output spi_input_clock, spi_input_data, spi_data_ack,
    input  spi_data_out, spi_data_valid, spi_busy, spi_overrun, spi_frame_error
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchronizers for the serial clock and data
// lines, with rising-edge detection on the synchronized clock.
//   clk_i      system clock
//   rst_i      synchronous active-high reset, clears every flop
//   sclk_i     asynchronous serial clock
//   sdata_i    asynchronous serial data
//   rise_o     one-cycle pulse: synced clock is 1 and was 0 the cycle before
//   sdata_o    synchronized data, aligned with rise_o
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic sdata_i,
  output logic rise_o,
  output logic sdata_o
);

  logic [STAGES-1:0] sclk_sync_q;
  logic [STAGES-1:0] sdata_sync_q;
  logic              sclk_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
      sclk_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[STAGES-2:0], sclk_i};
      sdata_sync_q <= {sdata_sync_q[STAGES-2:0], sdata_i};
      sclk_prev_q  <= sclk_sync_q[STAGES-1];
    end
  end

  // Both chains have equal depth, so the data bit seen in the rise cycle
  // is the one the transmitter set up before raising the clock.
  assign rise_o  = sclk_sync_q[STAGES-1] & ~sclk_prev_q;
  assign sdata_o = sdata_sync_q[STAGES-1];

endmodule

// File: rtl/spi_rx.sv
// spi_rx: SPI receiver, MSB first, data sampled on serial-clock rise.
// Reassembles bytes and offers them on a valid/ack handshake.
//   spi_clk    system clock, all logic on its rising edge
//   spi_reset  synchronous active-high reset
//   bus        spi_rx_if.slave: serial inputs, byte handshake, status
// Parameters:
//   SYNC_STAGES   flops per input synchronizer (>= 2)
//   IDLE_TIMEOUT  spi_clk cycles without a rise, mid-byte, before the
//                 partial byte is abandoned (1..65535)
module spi_rx
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic     spi_clk,
  input  logic     spi_reset,
  spi_rx_if.slave  bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_rx: SYNC_STAGES must be at least 2");
  end
  if (IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 65535) begin : g_bad_tmo
    $error("spi_rx: IDLE_TIMEOUT must be in 1..65535");
  end

  localparam logic [15:0] TMO_LIMIT = 16'(IDLE_TIMEOUT);

  logic rise;
  logic sdata;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (spi_clk),
    .rst_i   (spi_reset),
    .sclk_i  (bus.spi_input_clock),
    .sdata_i (bus.spi_input_data),
    .rise_o  (rise),
    .sdata_o (sdata)
  );

  spi_state_e            state_q,   state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0] shift_q,   shift_d;
  logic [15:0]           tmo_q,     tmo_d;
  logic [SPI_BYTE_W-1:0] data_q,    data_d;
  logic                  valid_q,   valid_d;
  logic                  overrun_q, overrun_d;
  logic                  ferr_q,    ferr_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] t);
    return (t == 16'hFFFF) ? t : t + 16'd1;
  endfunction

  always_ff @(posedge spi_clk) begin
    if (spi_reset) begin
      state_q   <= STATE_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = 1'b0;

    // Plain consume; a delivery in COMPLETE below takes precedence.
    if (valid_q && bus.spi_data_ack) valid_d = 1'b0;

    case (state_q)
      STATE_IDLE: begin
        tmo_d = '0;
        if (rise) begin
          shift_d   = {shift_q[SPI_BYTE_W-2:0], sdata};
          bit_cnt_d = 3'd1;
          state_d   = STATE_RECEIVE;
        end
      end

      STATE_RECEIVE: begin
        if (rise) begin
          shift_d = {shift_q[SPI_BYTE_W-2:0], sdata};
          tmo_d   = '0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = STATE_COMPLETE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          tmo_d = sat_inc(tmo_q);
          if (tmo_d == TMO_LIMIT) begin
            ferr_d    = 1'b1;
            shift_d   = '0;
            bit_cnt_d = 3'd0;
            tmo_d     = '0;
            state_d   = STATE_IDLE;
          end
        end
      end

      STATE_COMPLETE: begin
        // An ack in this same cycle frees the slot for the new byte.
        if (!valid_q || bus.spi_data_ack) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        tmo_d   = '0;
        state_d = STATE_IDLE;
        // A fast transmitter may already deliver bit 1 of the next byte.
        if (rise) begin
          shift_d   = {shift_q[SPI_BYTE_W-2:0], sdata};
          bit_cnt_d = 3'd1;
          state_d   = STATE_RECEIVE;
        end
      end

      default: begin
        state_d   = STATE_IDLE;
        bit_cnt_d = '0;
        tmo_d     = '0;
        shift_d   = '0;
      end
    endcase
  end

  assign bus.spi_data_out    = data_q;
  assign bus.spi_data_valid  = valid_q;
  assign bus.spi_busy        = (state_q == STATE_RECEIVE) || (state_q == STATE_COMPLETE);
  assign bus.spi_overrun     = overrun_q;
  assign bus.spi_frame_error = ferr_q;

endmodule

// File: tb/tb_spi_rx.sv
module tb_spi_rx;
  import spi_rx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic sdata = 1'b0;
  logic ack_man = 1'b0;
  logic ack_auto = 1'b0;

  always #5 clk = ~clk;

  spi_rx_if ifc ();

  assign ifc.spi_input_clock = sclk;
  assign ifc.spi_input_data  = sdata;
  assign ifc.spi_data_ack    = ack_auto ? ifc.spi_data_valid : ack_man;

  spi_rx #(
    .SYNC_STAGES  (2),
    .IDLE_TIMEOUT (64)
  ) dut (
    .spi_clk   (clk),
    .spi_reset (rst),
    .bus       (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observers: consumed bytes, frame-error cycles, valid-high cycles.
  logic [7:0] cap_q[$];
  int ferr_cnt = 0;
  int vld_cnt  = 0;
  always @(posedge clk) begin
    if (!rst && ifc.spi_data_valid && ifc.spi_data_ack) cap_q.push_back(ifc.spi_data_out);
    if (ifc.spi_frame_error) ferr_cnt <= ferr_cnt + 1;
    if (ifc.spi_data_valid)  vld_cnt  <= vld_cnt + 1;
  end

  // Reference: bytes expected to be consumed, in order.
  logic [7:0] exp_q[$];
  int cap_base = 0;

  // Reference of the output register for the no-ack scenario.
  logic [7:0] m_out;
  logic       m_valid;
  logic       m_ovr;

  task automatic model_complete(input logic [7:0] b);
    if (!m_valid) begin
      m_out   = b;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int ph);
    sdata = b;
    repeat (ph) @(negedge clk);
    sclk = 1'b1;
    repeat (ph) @(negedge clk);
    sclk = 1'b0;
  endtask

  // lat = negedges from the 8th-bit raise until valid is first seen (0 if not within ph).
  task automatic send_byte(input logic [7:0] b, input int ph, output int lat);
    lat = 0;
    for (int i = 7; i >= 1; i--) send_bit(b[i], ph);
    sdata = b[0];
    repeat (ph) @(negedge clk);
    sclk = 1'b1;
    for (int k = 1; k <= ph; k++) begin
      @(negedge clk);
      if (lat == 0 && ifc.spi_data_valid) lat = k;
    end
    sclk = 1'b0;
  endtask

  task automatic wait_valid(input int max, input string tag);
    int k = 0;
    while (!ifc.spi_data_valid && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(ifc.spi_data_valid), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, 32'(cap_q.size() - cap_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (cap_base + i < cap_q.size())
        chk($sformatf("%s_byte%0d", tag, i), 32'(cap_q[cap_base + i]), 32'(exp_q[i]));
      else
        chk($sformatf("%s_byte%0d", tag, i), 32'hDEAD, 32'(exp_q[i]));
    end
    exp_q.delete();
    cap_base = cap_q.size();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out"},   32'(ifc.spi_data_out),    32'd0);
    chk({tag, "_valid"}, 32'(ifc.spi_data_valid),  32'd0);
    chk({tag, "_busy"},  32'(ifc.spi_busy),        32'd0);
    chk({tag, "_ovr"},   32'(ifc.spi_overrun),     32'd0);
    chk({tag, "_ferr"},  32'(ifc.spi_frame_error), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int lat;
  int ferr_base;
  int vld_base;
  int first_k;
  logic [7:0] rb;
  int ph;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single byte, 12-cycle phase, ack tied to valid
    ack_auto = 1'b1;
    vld_base = vld_cnt;
    send_byte(8'hA5, 12, lat);
    chk("a5_latency", 32'(lat), 32'd4);
    exp_q.push_back(8'hA5);
    check_stream("a5");
    chk("a5_out_held", 32'(ifc.spi_data_out), 32'hA5);
    chk("a5_valid_cycles", 32'(vld_cnt - vld_base), 32'd1);
    chk("a5_valid_low", 32'(ifc.spi_data_valid), 32'd0);
    chk("a5_busy", 32'(ifc.spi_busy), 32'd0);
    chk("a5_ovr", 32'(ifc.spi_overrun), 32'd0);
    chk("a5_ferr", 32'(ferr_cnt), 32'd0);
    ack_auto = 1'b0;

    // Back-to-back bytes, ack 5 cycles after valid
    fork
      begin
        send_byte(8'h3C, 12, lat);
        send_byte(8'hC3, 12, lat);
      end
      begin
        for (int j = 0; j < 2; j++) begin
          wait_valid(400, "b2b_valid");
          repeat (5) @(negedge clk);
          ack_man = 1'b1;
          @(negedge clk);
          ack_man = 1'b0;
        end
      end
    join
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    check_stream("b2b");
    chk("b2b_ovr", 32'(ifc.spi_overrun), 32'd0);
    chk("b2b_valid", 32'(ifc.spi_data_valid), 32'd0);

    // Overrun: two bytes, no ack
    do_reset();
    m_out = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
    send_byte(8'h11, 12, lat);
    model_complete(8'h11);
    repeat (4) @(negedge clk);
    chk("ovr_first_out", 32'(ifc.spi_data_out), 32'(m_out));
    chk("ovr_first_flag", 32'(ifc.spi_overrun), 32'(m_ovr));
    send_byte(8'h22, 12, lat);
    model_complete(8'h22);
    repeat (4) @(negedge clk);
    chk("ovr_second_out", 32'(ifc.spi_data_out), 32'(m_out));
    chk("ovr_second_valid", 32'(ifc.spi_data_valid), 32'(m_valid));
    chk("ovr_second_flag", 32'(ifc.spi_overrun), 32'(m_ovr));
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    @(negedge clk);
    chk("ovr_after_ack_valid", 32'(ifc.spi_data_valid), 32'd0);
    chk("ovr_sticky", 32'(ifc.spi_overrun), 32'd1);
    cap_base = cap_q.size();
    do_reset();
    chk("ovr_cleared_by_reset", 32'(ifc.spi_overrun), 32'd0);

    // Timeout after 3 bits: pulse 64 cycles after the last detected rise
    ferr_base = ferr_cnt;
    send_bit(1'b1, 12);
    send_bit(1'b0, 12);
    sdata = 1'b1;
    repeat (12) @(negedge clk);
    sclk = 1'b1;
    first_k = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 12) sclk = 1'b0;
      if (k == 60) chk("tmo_busy_before", 32'(ifc.spi_busy), 32'd1);
      if (first_k == 0 && ifc.spi_frame_error) first_k = k;
    end
    chk("tmo_pulse_cycle", 32'(first_k), 32'd67);
    chk("tmo_pulse_width", 32'(ferr_cnt - ferr_base), 32'd1);
    chk("tmo_busy_after", 32'(ifc.spi_busy), 32'd0);
    ack_auto = 1'b1;
    send_byte(8'h81, 12, lat);
    exp_q.push_back(8'h81);
    check_stream("tmo_next");

    // Reset mid-byte discards the partial byte silently
    ferr_base = ferr_cnt;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 12);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("midreset_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);
    chk("midreset_idle", 32'(ifc.spi_busy), 32'd0);
    send_byte(8'hFF, 12, lat);
    exp_q.push_back(8'hFF);
    check_stream("midreset_next");

    // Loopback pattern at nominal and minimum phase
    for (int p = 0; p < 2; p++) begin
      ph = (p == 0) ? 12 : SPI_MIN_PHASE_CYCLES;
      send_byte(8'h5A, ph, lat); exp_q.push_back(8'h5A);
      send_byte(8'h00, ph, lat); exp_q.push_back(8'h00);
      send_byte(8'hFF, ph, lat); exp_q.push_back(8'hFF);
      repeat (10) @(negedge clk);
      check_stream(p == 0 ? "loop_ph12" : "loop_ph3");
    end

    // Random bytes at random phases
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom);
      ph = int'($urandom_range(12, SPI_MIN_PHASE_CYCLES));
      send_byte(rb, ph, lat);
      exp_q.push_back(rb);
    end
    repeat (10) @(negedge clk);
    check_stream("random");
    chk("final_ovr", 32'(ifc.spi_overrun), 32'd0);
    chk("final_ferr", 32'(ferr_cnt - ferr_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
